cpu_trace_buffer: RTL and testbench
===================================

// Module: cpu_trace_buffer
// PURPOSE
//  Synthesizable, parametrised trace capture that sits beside cpu and snoops register-file and data-memory writes.
//  Each event is logged with a cycle stamp and PC in a circular buffer. The buffer is drained via a valid/ready port.
//  Adds wrap/stop modes, overflow flag, halt detection and saturating cycle count, none of which the print-per-clock bench offers.
// PARAMETERS
//  DEPTH        16   entries in buffer; power of two, >=2
//  ADDR_W       32   PC / memory address width
//  DATA_W       32   register / memory data width
//  CYC_W        32   cycle-stamp width
//  HALT_CYCLES  4    consecutive cycles of unchanged PC that declare halt; >=2
// PORTS
//  clk        in   1                rising-edge clock
//  rst_n      in   1                asynchronous active-low reset
//  en         in   1                capture enable
//  clr        in   1                synchronous clear: buffer, flags, cycle
//  mode_wrap  in   1                1 = overwrite oldest when full; 0 = drop newest
//  pc         in   ADDR_W           current PC of cpu
//  rf_we      in   1                register write strobe
//  rf_waddr   in   5                register index
//  rf_wdata   in   DATA_W           register write data
//  mem_we     in   1                data-memory write strobe
//  mem_addr   in   ADDR_W           data-memory byte address
//  mem_wdata  in   DATA_W           data-memory write data
//  rd_valid   out  1                oldest entry available
//  rd_ready   in   1                consumer accepts entry
//  rd_kind    out  2                bit0 = rf write, bit1 = mem write
//  rd_cycle   out  CYC_W            cycle stamp of entry
//  rd_pc      out  ADDR_W           PC at capture
//  rd_reg     out  5                register index (0 if bit0 clear)
//  rd_rdata   out  DATA_W           register data
//  rd_maddr   out  ADDR_W           memory address
//  rd_mdata   out  DATA_W           memory data
//  count      out  $clog2(DEPTH)+1  entries held
//  overflow   out  1                sticky: an event was dropped or overwritten
//  halted     out  1                sticky: halt detected
//  cycle      out  CYC_W            current cycle count
// BEHAVIOUR
//  Reset: all outputs 0; pointers, count, flags, cycle, halt counter 0.
//  Precedence: clr > halt freeze > normal operation. clr applies the reset state in one cycle; a pop that cycle is discarded.
//  cycle increments every clk when en & !halted; saturates at all-ones (no wrap).
//  Event = en & !halted & ((rf_we & rf_waddr!=0) | mem_we). Both strobes in one cycle give ONE entry with rd_kind=2'b11.
//    A write to r0 alone is not an event.
//  Entry stamps the cycle value before increment. The entry is visible on rd_* the cycle after the event (1-cycle latency).
//  rd_valid = (count!=0). rd_* are driven combinationally from the entry at the read pointer and are stable while rd_valid & !rd_ready.
//  Pop = rd_valid & rd_ready: advance read pointer and decrement count. Pop is permitted while halted.
//  Push, not full: write at the write pointer, advance it, count+1.
//  Push+pop, any fill level: both pointers advance and count is unchanged. No overflow, even when full.
//  Push, full, no pop:
//    mode_wrap=1: overwrite oldest, advance both pointers, count stays DEPTH, overflow<=1.
//    mode_wrap=0: entry dropped, overflow<=1.
//  Pointers wrap modulo DEPTH.
//  Halt: a counter tracks cycles with en and pc == pc of the previous cycle. The counter resets on any change or when en=0.
//    When it reaches HALT_CYCLES-1, halted<=1. From then on no capture and cycle freezes until clr or reset.
//  rst_n assertion mid-operation clears immediately (async). The buffer storage contents need not be cleared.
// STRUCTURE
//  Shared package cpu_trace_pkg: TRACE_KIND_RF=2'b01, TRACE_KIND_MEM=2'b10, and the packed trace_entry_t struct
//    {kind, cycle, pc, reg, rdata, maddr, mdata}.
//  One sub-module, trace_halt_detect (pc compare plus counter, outputs halted). Circular buffer inline.
// TESTING
//  1 rf_we r8<=5 at cycle 3, pc=0x10 -> next cycle rd_valid=1, kind=01, rd_cycle=3, rd_reg=8, rd_rdata=5, count=1.
//  2 rf_we r0 plus mem_we addr 0x04 data 7 in one cycle -> a single entry, kind=10, maddr=4, mdata=7. A lone r0 write -> no entry.
//  3 mode_wrap=0, DEPTH+2 events, rd_ready=0 -> count=16, overflow=1, first popped entry is event 0.
//    With mode_wrap=1 -> first popped entry is event 2.
//  4 full buffer, push and pop in the same cycle -> count stays 16, overflow stays 0, rd_* advance to the next entry.
//  5 pc held at 0x20 for 4 cycles with en=1 -> halted=1, cycle frozen, later writes not captured, pops still drain.
//    Then clr -> count=0, halted=0, cycle=0.
//  6 rst_n low mid-drain, asynchronous to clk -> rd_valid, count, overflow, cycle all 0 before the next clk edge.

Source files
------------

// File: rtl/cpu_trace_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | cpu_trace_pkg : shared kinds and entry layout for the cpu trace logic |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
package cpu_trace_pkg;

  localparam logic [1:0] TRACE_KIND_RF  = 2'b01;
  localparam logic [1:0] TRACE_KIND_MEM = 2'b10;

  localparam int TRACE_ADDR_W = 32;
  localparam int TRACE_DATA_W = 32;
  localparam int TRACE_CYC_W  = 32;

  typedef struct packed {
    logic [1:0]              kind;
    logic [TRACE_CYC_W-1:0]  cycle;
    logic [TRACE_ADDR_W-1:0] pc;
    logic [4:0]              reg_idx;
    logic [TRACE_DATA_W-1:0] rdata;
    logic [TRACE_ADDR_W-1:0] maddr;
    logic [TRACE_DATA_W-1:0] mdata;
  } trace_entry_t;

endpackage
`default_nettype wire

// File: rtl/trace_halt_detect.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | trace_halt_detect : sticky halt flag after HALT_CYCLES of a stuck PC  |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module trace_halt_detect #(
  parameter int ADDR_W      = 32,
  parameter int HALT_CYCLES = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              en,
  input  logic [ADDR_W-1:0] pc,
  output logic              halted
);

  localparam int              CNT_W       = $clog2(HALT_CYCLES);
  localparam logic [CNT_W-1:0] c_halt_last = CNT_W'(HALT_CYCLES - 1);
  localparam logic [CNT_W-1:0] c_halt_arm  = CNT_W'(HALT_CYCLES - 2);

  logic [ADDR_W-1:0] r_prev_pc;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_halted;
  logic              w_same;

  assign w_same = en && (pc == r_prev_pc);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_prev_pc <= '0;
      r_cnt     <= '0;
      r_halted  <= 1'b0;
    end else if (clr) begin
      r_prev_pc <= '0;
      r_cnt     <= '0;
      r_halted  <= 1'b0;
    end else begin
      r_prev_pc <= pc;
      if (!r_halted) begin
        if (w_same) begin
          if (r_cnt != c_halt_last) r_cnt <= r_cnt + CNT_W'(1);
          // flag rises on the same edge the counter reaches its last value
          if (r_cnt == c_halt_arm) r_halted <= 1'b1;
        end else begin
          r_cnt <= '0;
        end
      end
    end
  end

  assign halted = r_halted;

endmodule
`default_nettype wire

// File: rtl/cpu_trace_buffer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | cpu_trace_buffer : circular trace of rf/mem writes, drained by v/r    |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module cpu_trace_buffer
  import cpu_trace_pkg::*;
#(
  parameter int DEPTH       = 16,
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int CYC_W       = 32,
  parameter int HALT_CYCLES = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       en,
  input  logic                       clr,
  input  logic                       mode_wrap,
  input  logic [ADDR_W-1:0]          pc,
  input  logic                       rf_we,
  input  logic [4:0]                 rf_waddr,
  input  logic [DATA_W-1:0]          rf_wdata,
  input  logic                       mem_we,
  input  logic [ADDR_W-1:0]          mem_addr,
  input  logic [DATA_W-1:0]          mem_wdata,
  output logic                       rd_valid,
  input  logic                       rd_ready,
  output logic [1:0]                 rd_kind,
  output logic [CYC_W-1:0]           rd_cycle,
  output logic [ADDR_W-1:0]          rd_pc,
  output logic [4:0]                 rd_reg,
  output logic [DATA_W-1:0]          rd_rdata,
  output logic [ADDR_W-1:0]          rd_maddr,
  output logic [DATA_W-1:0]          rd_mdata,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       overflow,
  output logic                       halted,
  output logic [CYC_W-1:0]           cycle
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             r_overflow;
  logic [CYC_W-1:0] r_cycle;
  trace_entry_t     r_mem [DEPTH];

  logic         w_halted;
  logic         w_rf_ev;
  logic         w_mem_ev;
  logic         w_push;
  logic         w_pop;
  logic         w_full;
  logic         w_wr;
  trace_entry_t w_entry;
  trace_entry_t w_head;

  trace_halt_detect #(
    .ADDR_W      (ADDR_W),
    .HALT_CYCLES (HALT_CYCLES)
  ) u_halt (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (clr),
    .en     (en),
    .pc     (pc),
    .halted (w_halted)
  );

  assign w_rf_ev  = rf_we && (rf_waddr != 5'd0);
  assign w_mem_ev = mem_we;
  assign w_push   = en && !w_halted && (w_rf_ev || w_mem_ev);
  assign w_pop    = rd_valid && rd_ready;
  assign w_full   = (r_count == CNT_W'(DEPTH));
  // a full buffer in drop mode only writes when a pop frees the head slot
  assign w_wr     = w_push && (w_pop || !w_full || mode_wrap);

  always_comb begin
    w_entry       = '0;
    w_entry.kind  = (w_rf_ev ? TRACE_KIND_RF : 2'b00) | (w_mem_ev ? TRACE_KIND_MEM : 2'b00);
    w_entry.cycle = TRACE_CYC_W'(r_cycle);
    w_entry.pc    = TRACE_ADDR_W'(pc);
    if (w_rf_ev) begin
      w_entry.reg_idx = rf_waddr;
      w_entry.rdata   = TRACE_DATA_W'(rf_wdata);
    end
    if (w_mem_ev) begin
      w_entry.maddr = TRACE_ADDR_W'(mem_addr);
      w_entry.mdata = TRACE_DATA_W'(mem_wdata);
    end
  end

  always_ff @(posedge clk) begin
    if (!clr && w_wr) r_mem[r_wr_ptr] <= w_entry;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
      r_cycle    <= '0;
    end else if (clr) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
      r_cycle    <= '0;
    end else begin
      if (en && !w_halted && (r_cycle != {CYC_W{1'b1}})) r_cycle <= r_cycle + CYC_W'(1);

      if (w_push && w_pop) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end else if (w_push && !w_full) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
        r_count  <= r_count + CNT_W'(1);
      end else if (w_push) begin
        r_overflow <= 1'b1;
        if (mode_wrap) begin
          r_wr_ptr <= r_wr_ptr + PTR_W'(1);
          r_rd_ptr <= r_rd_ptr + PTR_W'(1);
        end
      end else if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
        r_count  <= r_count - CNT_W'(1);
      end
    end
  end

  assign w_head   = r_mem[r_rd_ptr];
  assign rd_valid = (r_count != '0);

  always_comb begin
    rd_kind  = '0;
    rd_cycle = '0;
    rd_pc    = '0;
    rd_reg   = '0;
    rd_rdata = '0;
    rd_maddr = '0;
    rd_mdata = '0;
    if (rd_valid) begin
      rd_kind  = w_head.kind;
      rd_cycle = CYC_W'(w_head.cycle);
      rd_pc    = ADDR_W'(w_head.pc);
      rd_reg   = w_head.reg_idx;
      rd_rdata = DATA_W'(w_head.rdata);
      rd_maddr = ADDR_W'(w_head.maddr);
      rd_mdata = DATA_W'(w_head.mdata);
    end
  end

  assign count    = r_count;
  assign overflow = r_overflow;
  assign halted   = w_halted;
  assign cycle    = r_cycle;

endmodule
`default_nettype wire

// File: tb/tb_cpu_trace_buffer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_cpu_trace_buffer : directed vectors for cpu_trace_buffer           |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module tb_cpu_trace_buffer;

  logic        clk = 1'b0;
  logic        rst_n, en, clr, mode_wrap;
  logic [31:0] pc;
  logic        rf_we, mem_we, rd_ready;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata, mem_addr, mem_wdata;
  logic        rd_valid, overflow, halted;
  logic [1:0]  rd_kind;
  logic [31:0] rd_cycle, rd_pc, rd_rdata, rd_maddr, rd_mdata, cycle;
  logic [4:0]  rd_reg;
  logic [4:0]  count;

  int   checks   = 0;
  int   failures = 0;
  int   tb_cycle = 0;
  logic hold     = 1'b0;
  logic tb_halt  = 1'b0;

  cpu_trace_buffer dut (
    .clk(clk), .rst_n(rst_n), .en(en), .clr(clr), .mode_wrap(mode_wrap), .pc(pc),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_kind(rd_kind), .rd_cycle(rd_cycle),
    .rd_pc(rd_pc), .rd_reg(rd_reg), .rd_rdata(rd_rdata), .rd_maddr(rd_maddr),
    .rd_mdata(rd_mdata), .count(count), .overflow(overflow), .halted(halted), .cycle(cycle)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rf;
    logic [4:0]  ra;
    logic [31:0] rd;
    logic        m;
    logic [31:0] ma;
    logic [31:0] md;
    logic        push;
    logic [1:0]  kind;
    logic [4:0]  ereg;
  } vec_t;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // one clock; the bench keeps its own cycle model and walks pc unless held
  task automatic step();
    logic ena, c;
    ena = en & !tb_halt;
    c   = clr;
    @(posedge clk);
    #1;
    if (c) tb_cycle = 0;
    else if (ena) tb_cycle++;
    if (!hold) pc = pc + 32'd4;
  endtask

  task automatic ev(input logic rf, input logic [4:0] ra, input logic [31:0] rd,
                    input logic m, input logic [31:0] ma, input logic [31:0] md);
    rf_we = rf; rf_waddr = ra; rf_wdata = rd;
    mem_we = m; mem_addr = ma; mem_wdata = md;
    step();
    rf_we = 1'b0; mem_we = 1'b0;
  endtask

  task automatic do_clr();
    clr = 1'b1;
    step();
    clr = 1'b0;
  endtask

  task automatic pop1();
    rd_ready = 1'b1;
    step();
    rd_ready = 1'b0;
  endtask

  vec_t        tbl [5];
  int          stamp [5];
  logic [31:0] pcs [5];

  initial begin
    tbl[0] = '{rf:1, ra:5'd1,  rd:32'h11,   m:0, ma:32'h0,   md:32'h0,    push:1, kind:2'b01, ereg:5'd1};
    tbl[1] = '{rf:0, ra:5'd0,  rd:32'h0,    m:1, ma:32'h100, md:32'h22,   push:1, kind:2'b10, ereg:5'd0};
    tbl[2] = '{rf:1, ra:5'd31, rd:32'hdead, m:1, ma:32'h200, md:32'hbeef, push:1, kind:2'b11, ereg:5'd31};
    tbl[3] = '{rf:1, ra:5'd0,  rd:32'h33,   m:0, ma:32'h0,   md:32'h0,    push:0, kind:2'b00, ereg:5'd0};
    tbl[4] = '{rf:1, ra:5'd5,  rd:32'h55,   m:0, ma:32'h0,   md:32'h0,    push:1, kind:2'b01, ereg:5'd5};

    rst_n = 1'b0; en = 1'b0; clr = 1'b0; mode_wrap = 1'b0; pc = 32'h1000;
    rf_we = 1'b0; rf_waddr = '0; rf_wdata = '0; mem_we = 1'b0; mem_addr = '0; mem_wdata = '0;
    rd_ready = 1'b0;
    #12;
    chk("reset_valid", rd_valid, 0);
    chk("reset_count", count, 0);
    chk("reset_ovf", overflow, 0);
    chk("reset_halted", halted, 0);
    chk("reset_cycle", cycle, 0);
    chk("reset_kind", rd_kind, 0);
    rst_n = 1'b1;
    step();

    // single rf write at cycle 3
    en = 1'b1;
    step(); step(); step();
    chk("cycle_pre", cycle, 3);
    pc = 32'h10;
    ev(1'b1, 5'd8, 32'd5, 1'b0, 32'h0, 32'h0);
    chk("t1_valid", rd_valid, 1);
    chk("t1_kind", rd_kind, 2'b01);
    chk("t1_cycle", rd_cycle, 3);
    chk("t1_reg", rd_reg, 8);
    chk("t1_rdata", rd_rdata, 5);
    chk("t1_pc", rd_pc, 32'h10);
    chk("t1_count", count, 1);
    pop1();
    chk("t1_pop_count", count, 0);
    chk("t1_pop_valid", rd_valid, 0);

    // r0 plus mem write, then lone r0 write
    ev(1'b1, 5'd0, 32'h99, 1'b1, 32'h4, 32'd7);
    chk("t2_count", count, 1);
    chk("t2_kind", rd_kind, 2'b10);
    chk("t2_maddr", rd_maddr, 4);
    chk("t2_mdata", rd_mdata, 7);
    chk("t2_reg", rd_reg, 0);
    ev(1'b1, 5'd0, 32'h55, 1'b0, 32'h0, 32'h0);
    chk("t2_r0_count", count, 1);
    pop1();
    chk("t2_pop_count", count, 0);

    // table of mixed events, captured then drained in order
    for (int i = 0; i < 5; i++) begin
      stamp[i] = tb_cycle;
      pcs[i]   = pc;
      ev(tbl[i].rf, tbl[i].ra, tbl[i].rd, tbl[i].m, tbl[i].ma, tbl[i].md);
    end
    chk("tbl_count", count, 4);
    for (int i = 0; i < 5; i++) begin
      if (tbl[i].push) begin
        chk($sformatf("tbl%0d_kind", i), rd_kind, tbl[i].kind);
        chk($sformatf("tbl%0d_cycle", i), rd_cycle, stamp[i]);
        chk($sformatf("tbl%0d_pc", i), rd_pc, pcs[i]);
        chk($sformatf("tbl%0d_reg", i), rd_reg, tbl[i].ereg);
        if (tbl[i].rf) chk($sformatf("tbl%0d_rdata", i), rd_rdata, tbl[i].rd);
        if (tbl[i].m) begin
          chk($sformatf("tbl%0d_maddr", i), rd_maddr, tbl[i].ma);
          chk($sformatf("tbl%0d_mdata", i), rd_mdata, tbl[i].md);
        end
        pop1();
      end
    end
    chk("tbl_drained", count, 0);

    // overfill in drop mode, then in wrap mode
    do_clr();
    chk("t3_clr_cycle", cycle, 0);
    mode_wrap = 1'b0;
    for (int i = 0; i < 18; i++) ev(1'b1, 5'((i % 31) + 1), 32'(100 + i), 1'b0, 32'h0, 32'h0);
    chk("t3_drop_count", count, 16);
    chk("t3_drop_ovf", overflow, 1);
    chk("t3_drop_head", rd_rdata, 100);
    do_clr();
    chk("t3_clr_ovf", overflow, 0);
    mode_wrap = 1'b1;
    for (int i = 0; i < 18; i++) ev(1'b1, 5'((i % 31) + 1), 32'(100 + i), 1'b0, 32'h0, 32'h0);
    chk("t3_wrap_count", count, 16);
    chk("t3_wrap_ovf", overflow, 1);
    chk("t3_wrap_head", rd_rdata, 102);

    // async reset while draining
    rd_ready = 1'b1;
    step();
    chk("t6_pre_count", count, 15);
    #3;
    rst_n = 1'b0;
    #1;
    chk("t6_valid", rd_valid, 0);
    chk("t6_count", count, 0);
    chk("t6_ovf", overflow, 0);
    chk("t6_cycle", cycle, 0);
    rd_ready = 1'b0;
    tb_cycle = 0;
    #2;
    rst_n = 1'b1;
    step();

    // full buffer, simultaneous push and pop
    mode_wrap = 1'b0;
    do_clr();
    for (int i = 0; i < 16; i++) ev(1'b1, 5'd3, 32'(200 + i), 1'b0, 32'h0, 32'h0);
    chk("t4_full_count", count, 16);
    chk("t4_full_ovf", overflow, 0);
    chk("t4_head", rd_rdata, 200);
    rd_ready = 1'b1;
    ev(1'b1, 5'd3, 32'd300, 1'b0, 32'h0, 32'h0);
    rd_ready = 1'b0;
    chk("t4_pp_count", count, 16);
    chk("t4_pp_ovf", overflow, 0);
    chk("t4_pp_head", rd_rdata, 201);

    // halt on a stuck pc, drain while halted, then clear
    do_clr();
    ev(1'b1, 5'd4, 32'd400, 1'b0, 32'h0, 32'h0);
    ev(1'b1, 5'd4, 32'd401, 1'b0, 32'h0, 32'h0);
    hold = 1'b1;
    pc   = 32'h20;
    step(); step(); step();
    chk("t5_not_yet", halted, 0);
    step();
    chk("t5_halted", halted, 1);
    tb_halt = 1'b1;
    chk("t5_cycle_at_halt", cycle, 6);
    ev(1'b1, 5'd9, 32'h77, 1'b1, 32'h8, 32'h8);
    ev(1'b1, 5'd9, 32'h78, 1'b0, 32'h0, 32'h0);
    chk("t5_no_capture", count, 2);
    chk("t5_cycle_frozen", cycle, tb_cycle);
    chk("t5_head", rd_rdata, 400);
    pop1();
    chk("t5_pop_head", rd_rdata, 401);
    pop1();
    chk("t5_drained", count, 0);
    hold = 1'b0;
    do_clr();
    tb_halt = 1'b0;
    chk("t5_clr_count", count, 0);
    chk("t5_clr_halted", halted, 0);
    chk("t5_clr_cycle", cycle, 0);
    ev(1'b1, 5'd2, 32'd3, 1'b0, 32'h0, 32'h0);
    chk("t5_resume_count", count, 1);
    chk("t5_resume_stamp", rd_cycle, 0);
    chk("t5_resume_cycle", cycle, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
